hazard_controller: RTL
======================

// Module: hazard_controller
// PURPOSE
//  Hazard/stall scheduler for the 5-stage RV32I pipeline. Drives stall/flush enables of the F/D, D/E, E/M, M/W pipe regs.
//  Drives operand-forward selects into Execute. Sequences multi-cycle data-memory waits through a small FSM with a timeout.
//  Keeps saturating perf counters of stall cycles and branch flushes.
// PARAMETERS
//  REG_ADDR_WIDTH  5   register index width
//  MAX_WAIT        16  max consecutive dmem wait cycles before error (>=1)
//  COUNT_WIDTH     32  perf counter width
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   synchronous reset, active-high
//  Rs1D,Rs2D    in   RAW source regs of instr in Decode
//  Rs1E,Rs2E    in   RAW source regs of instr in Execute
//  RdE,RdM,RdW  in   RAW dest regs in Execute/Memory/Writeback
//  RegWriteM/W  in   1   instr in M/W writes regfile
//  LoadE        in   1   instr in Execute is a load
//  PCSrcE       in   1   branch/jump taken, resolved in Execute
//  MemReqM      in   1   instr in Memory accesses dmem
//  DmemReady    in   1   dmem completes access this cycle
//  ImemReady    in   1   imem returns valid instr this cycle
//  StallF,StallD,StallE,StallM  out 1  hold PC / pipe regs
//  FlushD,FlushE,FlushW         out 1  insert bubble into pipe reg
//  ForwardAE,ForwardBE          out 2  00 regfile, 01 from W, 10 from M
//  MemErr       out  1   sticky dmem timeout flag
//  StallCycles  out  COUNT_WIDTH  cycles with StallF=1
//  FlushCount   out  COUNT_WIDTH  taken-branch flushes
// BEHAVIOUR
//  Control outputs are combinational from state+inputs (same-cycle effect). State, wait counter and perf counters are registered.
//  Forwarding, A side (B identical with Rs2E):
//   - 10 if RegWriteM && RdM!=0 && RdM==Rs1E.
//   - else 01 if RegWriteW && RdW!=0 && RdW==Rs1E.
//   - else 00. Computed in every state.
//  Events:
//   - dwait = MemReqM && !DmemReady.
//   - lwStall = LoadE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
//   - br = PCSrcE.
//   - iwait = !ImemReady.
//  Priority (high->low) in RUN/DWAIT:
//   1. dwait: StallF=StallD=StallE=StallM=1, FlushW=1, others 0. br is held and takes effect after the wait.
//   2. br: FlushD=FlushE=1, all stalls 0. Overrides lwStall and iwait.
//   3. lwStall: StallF=StallD=1, FlushE=1. Exactly 1 bubble.
//   4. iwait: StallF=1, FlushD=1.
//   5. else: all 0.
//  FSM states: RUN, DWAIT, ERROR.
//   - RUN -> DWAIT when dwait.
//   - DWAIT -> RUN when !dwait. Stalls already released in that ready cycle.
//   - DWAIT -> ERROR when wait_cnt==MAX_WAIT-1 && dwait.
//   - ERROR: all stalls=1, FlushW=1, MemErr=1; stays until rst.
//  wait_cnt:
//   - Cleared in RUN.
//   - +1 per DWAIT cycle with dwait.
//   - Cleared on leaving DWAIT.
//  Perf counters:
//   - StallCycles +1 per cycle with StallF=1 (incl. ERROR).
//   - FlushCount +1 per cycle where rule 2 fires.
//   - Both saturate at all-ones.
//  Reset (rst=1 at edge): state=RUN, wait_cnt=0, MemErr=0, counters=0.
//  While rst is high: FlushD=FlushE=FlushW=1, stalls=0, Forward*=00.
//  rst mid-wait or in ERROR returns to RUN next cycle.
// TESTING
//  - Fwd: RdM=5,RegWriteM=1,RdW=5,RegWriteW=1,Rs1E=5 -> ForwardAE=10. Same with RdM=0 -> 01.
//  - Load-use: LoadE=1,RdE=7,Rs2D=7 -> 1 cycle StallF=StallD=FlushE=1. Next cycle (LoadE=0) all 0. StallCycles=1.
//  - Branch+lw same cycle: PCSrcE=1,lwStall=1 -> FlushD=FlushE=1, StallF=0. FlushCount=1.
//  - Dmem wait 3 cycles: MemReqM=1,DmemReady=0x3 then 1 -> 3 cycles all stalls+FlushW, state DWAIT. Released on ready cycle. StallCycles=3.
//  - Timeout: MAX_WAIT=4, DmemReady held 0 -> ERROR after 4th wait cycle. MemErr=1 sticky. rst -> RUN, MemErr=0.
//  - Counter saturation: COUNT_WIDTH=4, 20 stall cycles -> StallCycles=15.

Source files
------------

// File: rtl/hazard_controller.sv
// hazard_controller: stall/flush/forward scheduler for a 5-stage RV32I pipeline
// with a dmem-wait FSM (timeout to sticky error) and saturating perf counters.
module hazard_controller #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MAX_WAIT       = 16,
  parameter int COUNT_WIDTH    = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1E,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2E,
  input  logic [REG_ADDR_WIDTH-1:0] RdE,
  input  logic [REG_ADDR_WIDTH-1:0] RdM,
  input  logic [REG_ADDR_WIDTH-1:0] RdW,
  input  logic                      RegWriteM,
  input  logic                      RegWriteW,
  input  logic                      LoadE,
  input  logic                      PCSrcE,
  input  logic                      MemReqM,
  input  logic                      DmemReady,
  input  logic                      ImemReady,
  output logic                      StallF,
  output logic                      StallD,
  output logic                      StallE,
  output logic                      StallM,
  output logic                      FlushD,
  output logic                      FlushE,
  output logic                      FlushW,
  output logic [1:0]                ForwardAE,
  output logic [1:0]                ForwardBE,
  output logic                      MemErr,
  output logic [COUNT_WIDTH-1:0]    StallCycles,
  output logic [COUNT_WIDTH-1:0]    FlushCount
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  typedef enum logic [1:0] {RUN, DWAIT, ERROR} state_t;
  state_t                 state_q, state_d;
  logic [WW-1:0]          wait_q, wait_d;
  logic [COUNT_WIDTH-1:0] stall_q, stall_d, flush_q, flush_d;
  logic                   dwait, lw_stall, br, iwait, br_fire;
  function automatic logic [1:0] fwd(input logic [REG_ADDR_WIDTH-1:0] rs);
    return (RegWriteM && RdM != '0 && RdM == rs) ? 2'b10 :
           (RegWriteW && RdW != '0 && RdW == rs) ? 2'b01 : 2'b00;
  endfunction
  always_comb begin
    dwait    = MemReqM && !DmemReady;
    lw_stall = LoadE && RdE != '0 && (RdE == Rs1D || RdE == Rs2D);
    br       = PCSrcE;
    iwait    = !ImemReady;
    StallF   = 1'b0;
    StallD   = 1'b0;
    StallE   = 1'b0;
    StallM   = 1'b0;
    FlushD   = 1'b0;
    FlushE   = 1'b0;
    FlushW   = 1'b0;
    br_fire  = 1'b0;
    ForwardAE = rst ? 2'b00 : fwd(Rs1E);
    ForwardBE = rst ? 2'b00 : fwd(Rs2E);
    MemErr    = state_q == ERROR;
    if (rst) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else if (state_q == ERROR || dwait) begin
      // A pending branch stays in Execute under the stall and resolves afterwards.
      {StallF, StallD, StallE, StallM, FlushW} = 5'b11111;
    end else if (br) begin
      {FlushD, FlushE, br_fire} = 3'b111;
    end else if (lw_stall) begin
      {StallF, StallD, FlushE} = 3'b111;
    end else if (iwait) begin
      {StallF, FlushD} = 2'b11;
    end
    state_d = state_q;
    wait_d  = '0;
    if (state_q == RUN && dwait) state_d = DWAIT;
    if (state_q == DWAIT) begin
      state_d = !dwait ? RUN : (wait_q == WW'(MAX_WAIT - 1)) ? ERROR : DWAIT;
      wait_d  = (dwait && state_d == DWAIT) ? wait_q + 1'b1 : '0;
    end
    stall_d = (StallF && !(&stall_q)) ? stall_q + 1'b1 : stall_q;
    flush_d = (br_fire && !(&flush_q)) ? flush_q + 1'b1 : flush_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      wait_q  <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end
  assign StallCycles = stall_q;
  assign FlushCount  = flush_q;
endmodule
